mfp_uart_transmitter: RTL and testbench



---
 rtl/mfp_uart_transmitter_pkg.sv | 18 +
 rtl/mfp_uart_tx_fifo.sv | 52 +++++
 rtl/mfp_uart_transmitter.sv | 141 ++++++++++++++
 tb/tb_mfp_uart_transmitter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared types and helpers for the 8N1 UART transmitter.
// Holds the FSM state encoding and the bit-period calculation.
package mfp_uart_transmitter_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    function automatic int calc_div(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// Synchronous byte FIFO; head visible combinationally, push/pop take effect on the same edge.
// A push while full or a pop while empty is ignored.
module mfp_uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB separates a full ring from an empty one.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_pop_dat = r_mem[r_rptr[AW-1:0]];
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_push_dat;
        end
    end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter: bytes enter a FIFO via valid/ready and leave LSB-first on tx.
// First start bit begins one edge after the byte lands in the FIFO; wr_ready = !full.
module mfp_uart_transmitter
    import mfp_uart_transmitter_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_valid,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int            DIV       = calc_div(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int            BW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LOAD = BW'(DIV - 1);

    tx_state_t            r_state, w_state_nxt;
    logic [BW-1:0]        r_baud,  w_baud_nxt;
    logic [2:0]           r_bit,   w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_tx,    w_tx_nxt;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_head;

    assign w_push   = wr_valid && !w_full;
    assign wr_ready = !w_full;
    assign tx       = r_tx;
    assign busy     = !w_empty || (r_state != ST_IDLE);

    mfp_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (w_push),
        .i_push_dat (wr_data),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // r_tx is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_bit_nxt   = '0;
                    w_baud_nxt  = BAUD_LOAD;
                    w_state_nxt = ST_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (r_baud == '0) begin
                    w_baud_nxt  = BAUD_LOAD;
                    w_state_nxt = ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_baud_nxt  = r_baud - BW'(1);
                end
            end
            ST_DATA: begin
                if (r_baud == '0) begin
                    w_baud_nxt = BAUD_LOAD;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud - BW'(1);
                end
            end
            ST_STOP: begin
                if (r_baud == '0) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_bit_nxt   = '0;
                        w_baud_nxt  = BAUD_LOAD;
                        w_state_nxt = ST_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud - BW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Directed bench for mfp_uart_transmitter at DIV=8 (80-cycle frames).
module tb_mfp_uart_transmitter;

    localparam int CF  = 80;
    localparam int BR  = 10;
    localparam int DIV = 8;

    logic       clk      = 1'b0;
    logic       resetn   = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_ready;
    logic       tx;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mfp_uart_transmitter #(
        .CLOCK_FREQUENCY (CF),
        .BAUD_RATE       (BR),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .tx       (tx),
        .busy     (busy)
    );

    // Expected frame: bit i is the line level during bit time i
    // (0 = start, 1..8 = data LSB first, 9 = stop).
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        string      name;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_data  = d;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic idle_check(input int cycles, input string name);
        logic ok;
        ok = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Searches up to 'budget' negedges for the start bit, then checks all 80 cycles.
    task automatic check_frame(input logic [9:0] exp, input int budget, input string name);
        logic found;
        logic ok;
        found = 1'b0;
        for (int w = 0; w < budget; w++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_start: no start bit within %0d cycles, required one", name, budget);
            return;
        end
        for (int s = 0; s < 10; s++) begin
            ok = 1'b1;
            for (int c = 0; c < DIV; c++) begin
                if (!(s == 0 && c == 0)) @(negedge clk);
                if (tx !== exp[s]) ok = 1'b0;
            end
            check($sformatf("%s_slot%0d", name, s), 32'(ok), 32'd1);
        end
    endtask

    initial begin
        vecs[0] = '{data: 8'h80, frame: 10'h300, name: "f80"};
        vecs[1] = '{data: 8'h00, frame: 10'h200, name: "f00"};
        vecs[2] = '{data: 8'hFF, frame: 10'h3FE, name: "fFF"};
        vecs[3] = '{data: 8'hA5, frame: 10'h34A, name: "fA5"};
        vecs[4] = '{data: 8'h0F, frame: 10'h21E, name: "f0F"};
        vecs[5] = '{data: 8'h01, frame: 10'h202, name: "f01"};

        // Reset state and quiet line after release
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        resetn = 1'b1;
        idle_check(50, "idle_after_reset");

        // Single byte with exact start latency and busy drop
        write_byte(8'h55);
        @(negedge clk);
        check("tx_before_start", 32'(tx), 32'd1);
        check("busy_after_write", 32'(busy), 32'd1);
        check_frame(10'h2AA, 1, "f55");
        check("busy_last_stop_cycle", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_drop", 32'(busy), 32'd0);
        idle_check(10, "idle_after_55");

        // Fill: five writes fill FIFO behind the frame in flight, sixth ignored
        fork
            begin
                @(posedge clk);
                #1;
                wr_valid = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    wr_data = (i < 5) ? 8'(i + 1) : 8'hFF;
                    @(posedge clk);
                    #1;
                    if (i == 4) check("full_after_5th", 32'(wr_ready), 32'd0);
                end
                wr_valid = 1'b0;
            end
            begin
                check_frame(10'h202, 20, "fill1");
                check_frame(10'h204, 1, "fill2");
                check_frame(10'h206, 1, "fill3");
                check_frame(10'h208, 1, "fill4");
                check_frame(10'h20A, 1, "fill5");
            end
        join
        idle_check(120, "no_ff_frame");
        check("ready_after_drain", 32'(wr_ready), 32'd1);

        // Push on the exact edge the FSM pops at the end of a stop bit
        fork
            begin
                @(posedge clk);
                #1;
                wr_valid = 1'b1;
                wr_data  = 8'h11;
                @(posedge clk);
                #1;
                wr_data  = 8'h22;
                @(posedge clk);
                #1;
                wr_data  = 8'h33;
                @(posedge clk);
                #1;
                wr_data  = 8'h44;
                @(posedge clk);
                #1;
                wr_valid = 1'b0;
                repeat (77) @(posedge clk);
                #1;
                wr_valid = 1'b1;
                wr_data  = 8'hA5;
                @(posedge clk);
                #1;
                check("ready_after_pushpop", 32'(wr_ready), 32'd1);
                wr_data  = 8'h66;
                @(posedge clk);
                #1;
                check("full_after_extra", 32'(wr_ready), 32'd0);
                wr_valid = 1'b0;
            end
            begin
                check_frame(10'h222, 20, "pp11");
                check_frame(10'h244, 1, "pp22");
                check_frame(10'h266, 1, "pp33");
                check_frame(10'h288, 1, "pp44");
                check_frame(10'h34A, 1, "ppA5");
                check_frame(10'h2CC, 1, "pp66");
            end
        join
        idle_check(20, "idle_after_pushpop");

        // Reset during data bit 3 of 0x0F with two bytes queued
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_data  = 8'h0F;
        @(posedge clk);
        #1;
        wr_data  = 8'h01;
        @(posedge clk);
        #1;
        wr_data  = 8'h02;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        repeat (34) @(posedge clk);
        #3;
        check("bit3_level", 32'(tx), 32'd1);
        check("busy_mid_frame", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wr_ready", 32'(wr_ready), 32'd1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        idle_check(200, "no_frames_after_abort");

        // Table-driven single frames, including bit-order cases 0x80 and 0x00
        foreach (vecs[i]) begin
            write_byte(vecs[i].data);
            check_frame(vecs[i].frame, 3, vecs[i].name);
            idle_check(10, {vecs[i].name, "_idle"});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
